// File: rtl/issue_controller_pkg.sv
// Shared types for the issue stage: decoded instruction payload and issue FSM states.
package issue_controller_pkg;

   localparam int unsigned XLEN       = 32;
   localparam int unsigned REG_ADDR_W = 5;

   typedef logic [XLEN-1:0]       Word;
   typedef logic [REG_ADDR_W-1:0] RegAddress;
   typedef logic                  Bool;

   typedef enum logic [3:0] {
      OP_ADD,
      OP_SUB,
      OP_AND,
      OP_OR,
      OP_XOR,
      OP_SYSTEM
   } Opcode;

   typedef struct packed {
      Opcode     op;
      RegAddress rd;
      RegAddress rs1;
      RegAddress rs2;
      Bool       has_immediate;
      Word       immediate;
      Bool       is_ebreak;
   } Instruction;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      HALTED
   } IssueState;

   // Immediate forms take their second operand from the immediate, not rs2.
   function automatic Bool uses_rs2(input Instruction instr);
      return !instr.has_immediate;
   endfunction

endpackage

// File: rtl/issue_controller_if.sv
// Decode-to-issue handshake plus the registered issue output.
interface issue_controller_if;
   import issue_controller_pkg::*;

   logic       in_valid;
   logic       in_ready;
   Instruction in_instr;
   logic       issue_valid;
   Instruction issue_instr;

   modport master (
      output in_valid,
      output in_instr,
      input  in_ready,
      input  issue_valid,
      input  issue_instr
   );

   modport slave (
      input  in_valid,
      input  in_instr,
      output in_ready,
      output issue_valid,
      output issue_instr
   );

endinterface

// File: rtl/issue_controller_hazard_scoreboard.sv
// Shift register of in-flight register writes; flags RAW hazards against the current operands.
module issue_controller_hazard_scoreboard
   import issue_controller_pkg::*;
#(
   parameter int unsigned WB_LATENCY = 3
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  RegAddress push_rd,
   input  RegAddress rs1,
   input  RegAddress rs2,
   input  logic      use_rs2,
   output logic      hazard,
   output logic      empty
);

   // The oldest write is visible as it retires, so only WB_LATENCY-1 slots can block a read.
   localparam bit          TRACK = (WB_LATENCY > 1);
   localparam int unsigned DEPTH = TRACK ? WB_LATENCY - 1 : 1;

   logic [DEPTH-1:0] slot_valid;
   RegAddress        slot_rd [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_valid <= '0;
         for (int i = 0; i < int'(DEPTH); i++) slot_rd[i] <= '0;
      end else begin
         slot_valid[0] <= push && TRACK;
         slot_rd[0]    <= push_rd;
         for (int i = 1; i < int'(DEPTH); i++) begin
            slot_valid[i] <= slot_valid[i-1];
            slot_rd[i]    <= slot_rd[i-1];
         end
      end
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (slot_valid[i] && (slot_rd[i] != '0) &&
             ((slot_rd[i] == rs1) || (use_rs2 && (slot_rd[i] == rs2))))
            hazard = 1'b1;
      end
   end

   assign empty = (slot_valid == '0);

endmodule

// File: rtl/issue_controller.sv
// Issue sequencer: RAW-hazard stalls, EBREAK drain/halt, saturating stall counter.
module issue_controller
   import issue_controller_pkg::*;
#(
   parameter int unsigned WB_LATENCY  = 3,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   issue_controller_if.slave      bus,
   input  logic                   resume,
   output logic                   halted,
   output logic                   pipe_empty,
   output logic [STALL_CNT_W-1:0] stall_count
);

   IssueState state_q;
   IssueState state_d;
   logic      hazard;
   logic      sb_empty;
   logic      accept;
   logic      issue;
   logic      push;
   logic      stall;

   issue_controller_hazard_scoreboard #(
      .WB_LATENCY(WB_LATENCY)
   ) u_scoreboard (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .push_rd (bus.in_instr.rd),
      .rs1     (bus.in_instr.rs1),
      .rs2     (bus.in_instr.rs2),
      .use_rs2 (uses_rs2(bus.in_instr)),
      .hazard  (hazard),
      .empty   (sb_empty)
   );

   // Next state and handshake; EBREAK bypasses the hazard check and lets DRAIN wait instead.
   always_comb begin
      state_d      = state_q;
      bus.in_ready = 1'b0;
      unique case (state_q)
         RUN: begin
            bus.in_ready = !hazard || bus.in_instr.is_ebreak;
            if (bus.in_valid && bus.in_instr.is_ebreak) state_d = DRAIN;
         end
         DRAIN: begin
            if (sb_empty) state_d = HALTED;
         end
         HALTED: begin
            if (resume) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   assign accept     = bus.in_valid && bus.in_ready;
   assign issue      = accept && !bus.in_instr.is_ebreak;
   assign push       = issue && (bus.in_instr.rd != '0);
   assign stall      = (state_q == RUN) && bus.in_valid && !bus.in_ready;
   assign pipe_empty = sb_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= RUN;
         bus.issue_valid <= 1'b0;
         bus.issue_instr <= '0;
         halted          <= 1'b0;
         stall_count     <= '0;
      end else begin
         state_q         <= state_d;
         bus.issue_valid <= issue;
         if (issue) bus.issue_instr <= bus.in_instr;
         halted          <= (state_d == HALTED);
         if (stall && (stall_count != '1))
            stall_count <= stall_count + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_issue_controller.sv
// Self-checking bench for issue_controller: vector table plus directed drain/halt/reset sequences.
module tb_issue_controller;
   import issue_controller_pkg::*;

   localparam int unsigned CNT_W = 4;

   typedef struct {
      logic       valid;
      Instruction instr;
      int         exp_ready;
      int         exp_stall;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             resume;
   logic             halted;
   logic             pipe_empty;
   logic [CNT_W-1:0] stall_count;

   int errors = 0;
   int checks = 0;

   Instruction exp_q [$];

   issue_controller_if bus ();

   issue_controller #(
      .WB_LATENCY (3),
      .STALL_CNT_W(CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .resume     (resume),
      .halted     (halted),
      .pipe_empty (pipe_empty),
      .stall_count(stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic Instruction mk_r(input Opcode op, input int rd, input int rs1, input int rs2);
      Instruction i;
      i     = '0;
      i.op  = op;
      i.rd  = RegAddress'(rd);
      i.rs1 = RegAddress'(rs1);
      i.rs2 = RegAddress'(rs2);
      return i;
   endfunction

   function automatic Instruction mk_i(input int rd, input int rs1, input int imm, input int rs2f);
      Instruction i;
      i               = mk_r(OP_ADD, rd, rs1, rs2f);
      i.has_immediate = 1'b1;
      i.immediate     = Word'(imm);
      return i;
   endfunction

   function automatic Instruction mk_ebreak();
      Instruction i;
      i           = '0;
      i.op        = OP_SYSTEM;
      i.is_ebreak = 1'b1;
      return i;
   endfunction

   function automatic int sat(input int v);
      return (v > 15) ? 15 : v;
   endfunction

   task automatic drive(input logic v, input Instruction i);
      bus.in_valid = v;
      bus.in_instr = i;
   endtask

   // Mid-cycle sample: handshake checks, then scoreboard pop for the issue and push for a new accept.
   task automatic sample(input int exp_ready, input int exp_stall);
      Instruction e;
      @(negedge clk);
      if (exp_ready >= 0) check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
      if (exp_stall >= 0) check("stall_count", 64'(stall_count), 64'(exp_stall));
      check("issue_valid", 64'(bus.issue_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (bus.issue_valid) check("issue_instr", 64'(bus.issue_instr), 64'(e));
      end
      if (bus.in_valid && bus.in_ready && !bus.in_instr.is_ebreak) exp_q.push_back(bus.in_instr);
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   vec_t tbl [18];

   initial begin
      rst_n  = 1'b0;
      resume = 1'b0;
      drive(1'b0, '0);

      // back-to-back RAW, independent pair, x0 writes, immediate masking rs2, operand change while stalled
      tbl[0]  = '{1'b1, mk_i(1, 0, 5, 0),          1, 0};
      tbl[1]  = '{1'b1, mk_r(OP_ADD, 2, 1, 1),     0, 0};
      tbl[2]  = '{1'b1, mk_r(OP_ADD, 2, 1, 1),     0, 1};
      tbl[3]  = '{1'b1, mk_r(OP_ADD, 2, 1, 1),     1, 2};
      tbl[4]  = '{1'b0, '0,                        1, 2};
      tbl[5]  = '{1'b1, mk_r(OP_ADD, 3, 4, 5),     1, 2};
      tbl[6]  = '{1'b1, mk_r(OP_SUB, 6, 7, 8),     1, 2};
      tbl[7]  = '{1'b0, '0,                        1, 2};
      tbl[8]  = '{1'b1, mk_i(0, 0, 1, 0),          1, 2};
      tbl[9]  = '{1'b1, mk_r(OP_ADD, 1, 0, 0),     1, 2};
      tbl[10] = '{1'b1, mk_i(9, 0, 7, 1),          1, 2};
      tbl[11] = '{1'b1, mk_r(OP_ADD, 10, 0, 1),    0, 2};
      tbl[12] = '{1'b1, mk_r(OP_ADD, 10, 0, 1),    1, 3};
      tbl[13] = '{1'b0, '0,                        1, 3};
      tbl[14] = '{1'b1, mk_i(11, 0, 0, 0),         1, 3};
      tbl[15] = '{1'b1, mk_r(OP_ADD, 12, 11, 0),   0, 3};
      tbl[16] = '{1'b1, mk_r(OP_XOR, 13, 4, 4),    1, 4};
      tbl[17] = '{1'b0, '0,                        1, 4};

      // reset values
      advance();
      advance();
      check("rst_issue_valid", 64'(bus.issue_valid), 64'(0));
      check("rst_issue_instr", 64'(bus.issue_instr), 64'(0));
      check("rst_halted", 64'(halted), 64'(0));
      check("rst_pipe_empty", 64'(pipe_empty), 64'(1));
      check("rst_stall_count", 64'(stall_count), 64'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].valid, tbl[i].instr);
         sample(tbl[i].exp_ready, tbl[i].exp_stall);
         advance();
      end
      drive(1'b0, '0);
      sample(1, 4); advance();
      sample(1, 4); check("drained_empty", 64'(pipe_empty), 64'(1)); advance();

      // EBREAK behind a pending write: drain, halt, resume
      drive(1'b1, mk_i(1, 0, 1, 0));      sample(1, 4); advance();
      drive(1'b1, mk_ebreak());           sample(1, 4); advance();
      drive(1'b1, mk_r(OP_ADD, 2, 3, 3));
      resume = 1'b1;
      sample(0, 4);
      check("drain_halted", 64'(halted), 64'(0));
      check("drain_busy", 64'(pipe_empty), 64'(0));
      advance();
      resume = 1'b0;
      sample(0, 4);
      check("drain_halted_late", 64'(halted), 64'(0));
      check("drain_empty", 64'(pipe_empty), 64'(1));
      advance();
      sample(0, 4); check("halted_set", 64'(halted), 64'(1)); advance();
      resume = 1'b1;
      sample(0, 4); check("halted_hold", 64'(halted), 64'(1)); advance();
      resume = 1'b0;
      sample(1, 4); check("resumed", 64'(halted), 64'(0)); advance();
      drive(1'b0, '0);
      resume = 1'b1;
      sample(1, 4); advance();
      resume = 1'b0;
      sample(1, 4); check("resume_in_run", 64'(halted), 64'(0)); advance();

      // async reset mid-DRAIN
      drive(1'b1, mk_i(5, 0, 1, 0));      sample(1, 4); advance();
      drive(1'b1, mk_ebreak());           sample(1, 4); advance();
      drive(1'b0, '0);
      sample(0, 4);
      check("pre_rst_busy", 64'(pipe_empty), 64'(0));
      #1 rst_n = 1'b0;
      #1;
      check("drain_rst_empty", 64'(pipe_empty), 64'(1));
      check("drain_rst_halted", 64'(halted), 64'(0));
      check("drain_rst_issue", 64'(bus.issue_valid), 64'(0));
      check("drain_rst_stall", 64'(stall_count), 64'(0));
      check("drain_rst_ready", 64'(bus.in_ready), 64'(1));
      exp_q.delete();
      advance();
      rst_n = 1'b1;
      drive(1'b1, mk_r(OP_ADD, 2, 3, 4)); sample(1, 0); advance();
      drive(1'b0, '0);
      sample(1, 0);
      #1 rst_n = 1'b0;
      #1;
      check("issue_rst_valid", 64'(bus.issue_valid), 64'(0));
      check("issue_rst_instr", 64'(bus.issue_instr), 64'(0));
      exp_q.delete();
      advance();
      rst_n = 1'b1;

      // stall counter saturation (4-bit instance)
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, mk_i(1, 0, k, 0));      sample(1, sat(2 * k));     advance();
         drive(1'b1, mk_r(OP_ADD, 2, 1, 1)); sample(0, sat(2 * k));     advance();
         sample(0, sat(2 * k + 1)); advance();
         sample(1, sat(2 * k + 2)); advance();
      end
      drive(1'b0, '0);
      sample(1, 15); advance();

      // async reset while HALTED
      drive(1'b1, mk_i(1, 0, 3, 0));      sample(1, 15); advance();
      drive(1'b1, mk_ebreak());           sample(1, 15); advance();
      drive(1'b0, '0);
      sample(0, 15); advance();
      sample(0, 15); advance();
      sample(0, 15);
      check("halt_before_rst", 64'(halted), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      check("halt_rst_halted", 64'(halted), 64'(0));
      check("halt_rst_stall", 64'(stall_count), 64'(0));
      check("halt_rst_ready", 64'(bus.in_ready), 64'(1));
      exp_q.delete();
      advance();
      rst_n = 1'b1;
      advance();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
